// File: rtl/instr_mem_arbiter.sv
// Two-requester arbiter in front of the instruction RAM/boot-ROM wrapper.
// The loader wins by default; the core fetch port is protected from starvation.
module instr_mem_arbiter #(
    parameter int RAM_SIZE   = 32768,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE) + 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  core_req_i,
    input  logic [31:0]           core_addr_i,
    output logic                  core_gnt_o,
    output logic                  core_rvalid_o,
    output logic [31:0]           core_rdata_o,
    input  logic                  ld_req_i,
    input  logic                  ld_we_i,
    input  logic [3:0]            ld_be_i,
    input  logic [31:0]           ld_addr_i,
    input  logic [31:0]           ld_wdata_i,
    output logic                  ld_gnt_o,
    output logic                  ld_rvalid_o,
    output logic [31:0]           ld_rdata_o,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CORE,
        OWN_LD_RD,
        OWN_LD_WR
    } owner_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    owner_e     owner_q;
    owner_e     owner_d;
    logic [3:0] starve_cnt;
    logic [3:0] starve_d;

    // Byte-lane bits and decode bits above the RAM/ROM window are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{core_addr_i[31:ADDR_WIDTH+2], core_addr_i[1:0],
                                ld_addr_i[31:ADDR_WIDTH+2], ld_addr_i[1:0]};

    // Request stage: grant, memory drive and next owner are all decided in the request cycle.
    always_comb begin
        core_gnt_o  = 1'b0;
        ld_gnt_o    = 1'b0;
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_wdata_o = 32'h0;
        owner_d     = OWN_NONE;
        starve_d    = starve_cnt;

        if (core_req_i && (!ld_req_i || starve_cnt == STARVE_LIM)) begin
            core_gnt_o = 1'b1;
            mem_addr_o = core_addr_i[ADDR_WIDTH+1:2];
            mem_be_o   = 4'hF;
            owner_d    = OWN_CORE;
        end else if (ld_req_i) begin
            ld_gnt_o    = 1'b1;
            mem_addr_o  = ld_addr_i[ADDR_WIDTH+1:2];
            mem_we_o    = ld_we_i;
            mem_be_o    = ld_be_i;
            mem_wdata_o = ld_wdata_i;
            owner_d     = ld_we_i ? OWN_LD_WR : OWN_LD_RD;
        end

        // Counts loader wins while the core waits; saturates at the limit.
        if (core_gnt_o || !core_req_i) begin
            starve_d = 4'h0;
        end else if (ld_gnt_o && starve_cnt != STARVE_LIM) begin
            starve_d = starve_cnt + 4'd1;
        end
    end

    assign mem_en_o = core_gnt_o | ld_gnt_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= OWN_NONE;
            starve_cnt <= 4'h0;
        end else begin
            owner_q    <= owner_d;
            starve_cnt <= starve_d;
        end
    end

    // Response stage: route the single-cycle memory return to whoever owned last cycle.
    assign core_rvalid_o = (owner_q == OWN_CORE);
    assign core_rdata_o  = (owner_q == OWN_CORE) ? mem_rdata_i : 32'h0;
    assign ld_rvalid_o   = (owner_q == OWN_LD_RD) || (owner_q == OWN_LD_WR);
    assign ld_rdata_o    = (owner_q == OWN_LD_RD) ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Directed bench for instr_mem_arbiter: grants, memory drive, response routing,
// starvation limit and asynchronous reset behaviour.
module tb_instr_mem_arbiter;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          core_req_i;
    logic [31:0]   core_addr_i;
    logic          core_gnt_o;
    logic          core_rvalid_o;
    logic [31:0]   core_rdata_o;
    logic          ld_req_i;
    logic          ld_we_i;
    logic [3:0]    ld_be_i;
    logic [31:0]   ld_addr_i;
    logic [31:0]   ld_wdata_i;
    logic          ld_gnt_o;
    logic          ld_rvalid_o;
    logic [31:0]   ld_rdata_o;
    logic          mem_en_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_we_o;
    logic [3:0]    mem_be_o;
    logic [31:0]   mem_wdata_o;
    logic [31:0]   mem_rdata_i;

    int checks   = 0;
    int failures = 0;

    logic exp_core [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic exp_post [5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    instr_mem_arbiter #(
        .RAM_SIZE   (32768),
        .ADDR_WIDTH (AW),
        .STARVE_MAX (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .core_req_i    (core_req_i),
        .core_addr_i   (core_addr_i),
        .core_gnt_o    (core_gnt_o),
        .core_rvalid_o (core_rvalid_o),
        .core_rdata_o  (core_rdata_o),
        .ld_req_i      (ld_req_i),
        .ld_we_i       (ld_we_i),
        .ld_be_i       (ld_be_i),
        .ld_addr_i     (ld_addr_i),
        .ld_wdata_i    (ld_wdata_i),
        .ld_gnt_o      (ld_gnt_o),
        .ld_rvalid_o   (ld_rvalid_o),
        .ld_rdata_o    (ld_rdata_o),
        .mem_en_o      (mem_en_o),
        .mem_addr_o    (mem_addr_o),
        .mem_we_o      (mem_we_o),
        .mem_be_o      (mem_be_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        core_req_i  = 1'b0;
        core_addr_i = 32'h0;
        ld_req_i    = 1'b0;
        ld_we_i     = 1'b0;
        ld_be_i     = 4'h0;
        ld_addr_i   = 32'h0;
        ld_wdata_i  = 32'h0;
        mem_rdata_i = 32'h0;

        // Reset state with garbage on the memory read bus
        @(posedge clk); #1;
        mem_rdata_i = 32'hFFFF_FFFF;
        #2;
        chk("rst_core_rvalid", core_rvalid_o, 0);
        chk("rst_ld_rvalid", ld_rvalid_o, 0);
        chk("rst_core_rdata", core_rdata_o, 0);
        chk("rst_ld_rdata", ld_rdata_o, 0);
        chk("rst_mem_en", mem_en_o, 0);
        chk("rst_gnts", {core_gnt_o, ld_gnt_o}, 0);
        rst_n = 1'b1;

        // Single core read of 0x10
        @(posedge clk); #1;
        core_req_i = 1'b1; core_addr_i = 32'h0000_0010; mem_rdata_i = 32'h0;
        #2;
        chk("c_rd_gnt", core_gnt_o, 1);
        chk("c_rd_ld_gnt", ld_gnt_o, 0);
        chk("c_rd_en", mem_en_o, 1);
        chk("c_rd_addr", mem_addr_o, 4);
        chk("c_rd_we", mem_we_o, 0);
        chk("c_rd_be", mem_be_o, 4'hF);
        chk("c_rd_wdata", mem_wdata_o, 0);
        @(posedge clk); #1;
        core_req_i = 1'b0; mem_rdata_i = 32'hDEAD_BEEF;
        #2;
        chk("c_rd_rvalid", core_rvalid_o, 1);
        chk("c_rd_rdata", core_rdata_o, 32'hDEAD_BEEF);
        chk("c_rd_ld_rvalid", ld_rvalid_o, 0);
        chk("c_rd_ld_rdata", ld_rdata_o, 0);
        chk("c_rd_idle_en", mem_en_o, 0);

        // Loader write to 0x20
        @(posedge clk); #1;
        ld_req_i = 1'b1; ld_we_i = 1'b1; ld_be_i = 4'b0011;
        ld_addr_i = 32'h0000_0020; ld_wdata_i = 32'h1234_5678; mem_rdata_i = 32'h0;
        #2;
        chk("l_wr_gnt", ld_gnt_o, 1);
        chk("l_wr_core_gnt", core_gnt_o, 0);
        chk("l_wr_addr", mem_addr_o, 8);
        chk("l_wr_we", mem_we_o, 1);
        chk("l_wr_be", mem_be_o, 4'b0011);
        chk("l_wr_wdata", mem_wdata_o, 32'h1234_5678);
        @(posedge clk); #1;
        ld_req_i = 1'b0; ld_we_i = 1'b0; mem_rdata_i = 32'hA5A5_A5A5;
        #2;
        chk("l_wr_rvalid", ld_rvalid_o, 1);
        chk("l_wr_rdata", ld_rdata_o, 0);
        chk("l_wr_core_rvalid", core_rvalid_o, 0);

        // Loader read of boot ROM at 0x20000
        @(posedge clk); #1;
        ld_req_i = 1'b1; ld_we_i = 1'b0; ld_be_i = 4'hF; ld_addr_i = 32'h0002_0000;
        mem_rdata_i = 32'h0;
        #2;
        chk("l_rom_addr", mem_addr_o, 16'h8000);
        chk("l_rom_we", mem_we_o, 0);
        @(posedge clk); #1;
        ld_req_i = 1'b0; mem_rdata_i = 32'hCAFE_F00D;
        #2;
        chk("l_rom_rvalid", ld_rvalid_o, 1);
        chk("l_rom_rdata", ld_rdata_o, 32'hCAFE_F00D);
        chk("l_rom_core_rdata", core_rdata_o, 0);

        // Core fetch with junk in ignored byte and upper address bits
        @(posedge clk); #1;
        core_req_i = 1'b1; core_addr_i = 32'hF000_0007; mem_rdata_i = 32'h0;
        #2;
        chk("c_mask_addr", mem_addr_o, 1);
        @(posedge clk); #1;
        core_req_i = 1'b0;

        // Back-to-back core fetches 0x0, 0x4, 0x8
        @(posedge clk); #1;
        core_req_i = 1'b1; core_addr_i = 32'h0;
        #2;
        chk("b2b_gnt0", core_gnt_o, 1);
        chk("b2b_addr0", mem_addr_o, 0);
        @(posedge clk); #1;
        core_addr_i = 32'h4; mem_rdata_i = 32'h0000_0100;
        #2;
        chk("b2b_gnt1", core_gnt_o, 1);
        chk("b2b_addr1", mem_addr_o, 1);
        chk("b2b_rv0", core_rvalid_o, 1);
        chk("b2b_rd0", core_rdata_o, 32'h0000_0100);
        @(posedge clk); #1;
        core_addr_i = 32'h8; mem_rdata_i = 32'h0000_0104;
        #2;
        chk("b2b_gnt2", core_gnt_o, 1);
        chk("b2b_addr2", mem_addr_o, 2);
        chk("b2b_rv1", core_rvalid_o, 1);
        chk("b2b_rd1", core_rdata_o, 32'h0000_0104);
        @(posedge clk); #1;
        core_req_i = 1'b0; mem_rdata_i = 32'h0000_0108;
        #2;
        chk("b2b_gnt_off", core_gnt_o, 0);
        chk("b2b_rv2", core_rvalid_o, 1);
        chk("b2b_rd2", core_rdata_o, 32'h0000_0108);
        @(posedge clk); #1;
        mem_rdata_i = 32'h0;
        #2;
        chk("b2b_rv_end", core_rvalid_o, 0);

        // Both requesting continuously: L,L,L,L,C,L,L,L,L,C
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            core_req_i = 1'b1; core_addr_i = 32'h100;
            ld_req_i = 1'b1; ld_we_i = 1'b0; ld_be_i = 4'hF; ld_addr_i = 32'h200;
            mem_rdata_i = 32'h5000_0000 + i;
            #2;
            chk($sformatf("stv_core_gnt%0d", i), core_gnt_o, exp_core[i]);
            chk($sformatf("stv_ld_gnt%0d", i), ld_gnt_o, !exp_core[i]);
            if (i > 0) begin
                chk($sformatf("stv_core_rv%0d", i), core_rvalid_o, exp_core[i-1]);
                chk($sformatf("stv_ld_rv%0d", i), ld_rvalid_o, !exp_core[i-1]);
                chk($sformatf("stv_core_rd%0d", i), core_rdata_o,
                    exp_core[i-1] ? 32'h5000_0000 + i : 32'h0);
                chk($sformatf("stv_ld_rd%0d", i), ld_rdata_o,
                    exp_core[i-1] ? 32'h0 : 32'h5000_0000 + i);
            end
        end
        @(posedge clk); #1;
        core_req_i = 1'b0; ld_req_i = 1'b0; mem_rdata_i = 32'h5000_000A;
        #2;
        chk("stv_last_core_rv", core_rvalid_o, 1);
        chk("stv_last_core_rd", core_rdata_o, 32'h5000_000A);
        chk("stv_last_ld_rv", ld_rvalid_o, 0);

        // Reset asserted right after a core grant: response suppressed
        @(posedge clk); #1;
        core_req_i = 1'b1; core_addr_i = 32'h40; mem_rdata_i = 32'h0;
        #2;
        chk("mrst_gnt", core_gnt_o, 1);
        chk("mrst_addr", mem_addr_o, 16'h0010);
        #1;
        rst_n = 1'b0; core_req_i = 1'b0;
        @(posedge clk); #1;
        mem_rdata_i = 32'h7777_7777;
        #2;
        chk("mrst_core_rv", core_rvalid_o, 0);
        chk("mrst_core_rd", core_rdata_o, 0);
        chk("mrst_ld_rv", ld_rvalid_o, 0);
        rst_n = 1'b1;
        @(posedge clk); #3;
        chk("mrst_post_core_rv", core_rvalid_o, 0);
        chk("mrst_post_ld_rv", ld_rvalid_o, 0);

        // Build up starvation, reset, then the count must restart from zero
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            core_req_i = 1'b1; core_addr_i = 32'h300;
            ld_req_i = 1'b1; ld_we_i = 1'b0; ld_addr_i = 32'h400;
            #2;
        end
        chk("srst_pre_ld_gnt", ld_gnt_o, 1);
        #1;
        rst_n = 1'b0; core_req_i = 1'b0; ld_req_i = 1'b0;
        @(posedge clk); #3;
        chk("srst_ld_rv", ld_rvalid_o, 0);
        chk("srst_ld_rd", ld_rdata_o, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            core_req_i = 1'b1; ld_req_i = 1'b1;
            #2;
            chk($sformatf("srst_core_gnt%0d", i), core_gnt_o, exp_post[i]);
        end
        @(posedge clk); #1;
        core_req_i = 1'b0; ld_req_i = 1'b0;
        #2;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_mem_arbiter.md
Name: instr_mem_arbiter

Overview:
- Sits directly upstream of the instruction RAM/boot-ROM wrapper.
- Merges two requesters onto the wrapper's single-port en/addr/we/be interface:
  - the core instruction-fetch port, read-only;
  - the loader/debug port, read/write.
- Both requesters use the PULP req/gnt/rvalid protocol. The block generates grants and word addresses, and tracks the one-cycle memory latency to route rdata/rvalid back to the correct requester.
- Includes anti-starvation for the core fetch port.

Parameters:
- RAM_SIZE, 32768, instruction RAM depth in 32-bit words.
- ADDR_WIDTH, $clog2(RAM_SIZE)+1, width of the word address to the wrapper; the MSB selects the boot ROM.
- STARVE_MAX, 4, maximum consecutive loader grants while the core is waiting (range 1..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- core_req_i  in  1  core fetch request
- core_addr_i  in  32  core byte address
- core_gnt_o  out  1  core request accepted this cycle
- core_rvalid_o  out  1  core read data valid
- core_rdata_o  out  32  core read data
- ld_req_i  in  1  loader request
- ld_we_i  in  1  loader write enable
- ld_be_i  in  4  loader byte enables
- ld_addr_i  in  32  loader byte address
- ld_wdata_i  in  32  loader write data
- ld_gnt_o  out  1  loader request accepted
- ld_rvalid_o  out  1  loader response (read data or write ack)
- ld_rdata_o  out  32  loader read data
- mem_en_o  out  1  memory access enable
- mem_addr_o  out  ADDR_WIDTH  memory word address
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  memory byte enables
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data, valid one cycle after mem_en_o

Behaviour:
- Clocking/reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset values:
  - registered state: owner_q=NONE, starve_cnt=0;
  - outputs: all rvalid outputs 0, all rdata outputs 0.
  - gnt and mem_* outputs are combinational from requests; they are 0 when no request is present.
- Grant decision (combinational, same cycle as req):
  - Loader has priority by default.
  - The core wins if core_req_i && (!ld_req_i || starve_cnt==STARVE_MAX).
  - At most one gnt is asserted per cycle; mem_en_o = core_gnt_o | ld_gnt_o.
- Memory drive, core granted:
  - mem_addr_o = core_addr_i[ADDR_WIDTH+1:2];
  - mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
- Memory drive, loader granted:
  - mem_addr_o = ld_addr_i[ADDR_WIDTH+1:2];
  - mem_we_o=ld_we_i, mem_be_o=ld_be_i, mem_wdata_o=ld_wdata_i.
- Address handling: byte address bits [1:0] are ignored. Upper bits above ADDR_WIDTH+1 are ignored; upstream decoding owns them.
- starve_cnt (registered, saturating):
  - increments when ld_gnt_o && core_req_i;
  - clears when core_gnt_o, or when core_req_i==0;
  - otherwise holds.
- Response tracking:
  - owner_q ∈ {NONE, CORE, LD_RD, LD_WR} is registered from the grant each cycle.
  - Next cycle: the matching rvalid is 1 for exactly one cycle.
  - core_rdata_o = mem_rdata_i when owner_q==CORE, else 0.
  - ld_rdata_o = mem_rdata_i when owner_q==LD_RD, else 0. A write ack (LD_WR) returns rdata 0.
- Latency and throughput:
  - Fixed latency: gnt at cycle N, rvalid at N+1.
  - Back-to-back grants are allowed every cycle. A new grant at N+1 overlaps the response for N.
- Upstream rules:
  - A requester holds req, addr, we, be and wdata stable until its gnt.
  - A requester may drop req only after gnt.
- Simultaneous request while the core is starved (starve_cnt==STARVE_MAX): the core is granted, the counter clears, and the loader waits at least one cycle.
- Reset asserted mid-transaction: a pending rvalid is suppressed; no response is ever produced for that grant.
- No internal buffering: the memory-side rdata is only guaranteed in the cycle after access. Consumers must take rdata on rvalid.

Test Plan:
- Reset, then a single core read of 0x0000_0010 while the RAM returns 0xDEADBEEF:
  - cycle 0: core_gnt_o=1, mem_addr_o=4, mem_we_o=0, mem_be_o=4'hF;
  - cycle 1: core_rvalid_o=1, core_rdata_o=0xDEADBEEF, ld_rvalid_o=0.
- Loader write to 0x0000_0020, be=4'b0011, wdata=0x12345678:
  - mem_addr_o=8, mem_we_o=1, mem_be_o=4'b0011;
  - next cycle: ld_rvalid_o=1, ld_rdata_o=0.
- Loader read of 0x0002_0000 (boot ROM, ADDR_WIDTH=16):
  - mem_addr_o=16'h8000;
  - ld_rvalid_o=1 one cycle later with mem_rdata_i passed through.
- Core and loader both requesting continuously, STARVE_MAX=4:
  - grant sequence is L,L,L,L,C,L,L,L,L,C,…;
  - each rvalid is routed to the matching port with no loss or duplication.
- Back-to-back core fetches of 0x0, 0x4, 0x8 on consecutive cycles: three gnts and three rvalids, each rvalid one cycle after its gnt, with rdata in address order.
- rst_n asserted low the cycle after a core grant: core_rvalid_o stays 0, owner_q returns to NONE, starve_cnt returns to 0, and no response appears after reset is released.
